if_fetch_unit: RTL and testbench

Instruction-fetch stage of the 16-bit MIPS pipeline: holds the 4-bit program counter, a 16-entry x 16-bit instruction memory and the next-PC selection logic (sequential, branch redirect, stall, halt). It sits directly upstream of the IF/ID pipeline register and drives its `pcadd4` and `inst` inputs each cycle. Control inputs (stall, branch redirect) come from the hazard unit and the branch resolution logic in later stages.

---
 rtl/if_fetch_unit.sv | 103 ++++++++++
 tb/tb_if_fetch_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction-fetch stage: PC, 16x16 instruction memory, next-PC FSM
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   stall           hold PC and output; no fetch counted
//   branch_taken    redirect PC to branch_target on next edge (wins over stall)
//   branch_target   4-bit redirect word address
//   prog_we/addr/data  instruction-memory write port (clocked)
//   pc, pcadd4      current PC and pc + 1 (mod 16)
//   inst, inst_valid   fetched word (NOP_INST when not valid) and its qualifier
//   flush           combinational copy of branch_taken
//   halted          high while parked in HALT
//   fetch_count     issued-instruction counter, saturating at 255
module if_fetch_unit #(
  parameter logic [15:0] HALT_INST = 16'hFFFF,
  parameter logic [15:0] NOP_INST  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [3:0]  branch_target,
  input  logic        prog_we,
  input  logic [3:0]  prog_addr,
  input  logic [15:0] prog_data,
  output logic [3:0]  pc,
  output logic [3:0]  pcadd4,
  output logic [15:0] inst,
  output logic        inst_valid,
  output logic        flush,
  output logic        halted,
  output logic [7:0]  fetch_count
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]  state;
  logic [1:0]  next_state;
  logic [3:0]  next_pc;
  logic [15:0] imem [16];
  logic [15:0] cur_word;

  // Combinational read: a write to imem[pc] this cycle shows up next cycle.
  assign cur_word   = imem[pc];
  assign pcadd4     = pc + 4'd1;
  assign inst_valid = (state == ST_RUN) && !branch_taken;
  assign inst       = inst_valid ? cur_word : NOP_INST;
  assign flush      = branch_taken;
  assign halted     = (state == ST_HALT);

  always_comb begin
    next_pc    = pc;
    next_state = state;
    if (branch_taken) begin
      // A redirect always lands in RUN, from any state.
      next_pc    = branch_target;
      next_state = ST_RUN;
    end else begin
      case (state)
        ST_BOOT: next_state = ST_RUN;  // PC held so word 0 is the first fetch
        ST_RUN: begin
          if (!stall) begin
            if (cur_word == HALT_INST) begin
              // Halt word issues this cycle; PC parks on it.
              next_state = ST_HALT;
            end else begin
              next_pc = pcadd4;
            end
          end
        end
        ST_HALT: next_state = ST_HALT;
        default: next_state = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= 4'd0;
      state       <= ST_BOOT;
      fetch_count <= 8'd0;
    end else begin
      pc    <= next_pc;
      state <= next_state;
      if (inst_valid && !stall && (fetch_count != 8'hFF)) begin
        fetch_count <= fetch_count + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        imem[i] <= NOP_INST;
      end
    end else if (prog_we) begin
      imem[prog_addr] <= prog_data;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [3:0]  branch_target;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [15:0] prog_data;
  logic [3:0]  pc;
  logic [3:0]  pcadd4;
  logic [15:0] inst;
  logic        inst_valid;
  logic        flush;
  logic        halted;
  logic [7:0]  fetch_count;

  if_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .pc(pc), .pcadd4(pcadd4), .inst(inst),
    .inst_valid(inst_valid), .flush(flush), .halted(halted),
    .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: memory array, PC as an integer, two mode flags.
  logic [15:0] m_mem [16];
  int          m_pc;
  bit          m_boot;
  bit          m_halt;
  int          m_cnt;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 16'h0000;
    m_pc   = 0;
    m_boot = 1;
    m_halt = 0;
    m_cnt  = 0;
  endtask

  function automatic bit m_valid();
    return !m_boot && !m_halt && !branch_taken;
  endfunction

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_update();
    bit issued;
    logic [15:0] word;
    if (!rst_n) begin
      model_reset();
      return;
    end
    issued = m_valid();
    word   = m_mem[m_pc];
    if (issued && !stall && m_cnt < 255) m_cnt++;
    if (branch_taken) begin
      m_pc = branch_target; m_boot = 0; m_halt = 0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (!m_halt && !stall) begin
      if (word == 16'hFFFF) m_halt = 1;
      else m_pc = (m_pc + 1) % 16;
    end
    if (prog_we) m_mem[prog_addr] = prog_data;
  endtask

  task automatic compare();
    bit v;
    v = m_valid();
    chk("pc", pc, m_pc);
    chk("pcadd4", pcadd4, (m_pc + 1) % 16);
    chk("inst_valid", inst_valid, v);
    chk("inst", inst, v ? m_mem[m_pc] : 16'h0000);
    chk("flush", flush, branch_taken);
    chk("halted", halted, m_halt);
    chk("fetch_count", fetch_count, m_cnt);
  endtask

  task automatic drive(input bit s, input bit bt, input int tgt,
                       input bit we, input int addr, input logic [15:0] data);
    stall = s; branch_taken = bt; branch_target = 4'(tgt);
    prog_we = we; prog_addr = 4'(addr); prog_data = data;
  endtask

  task automatic settle();
    @(negedge clk);
    compare();
  endtask

  task automatic adv();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cyc();
    settle();
    adv();
  endtask

  initial begin
    logic [15:0] prog [4];
    prog[0] = 16'h1111; prog[1] = 16'h2222; prog[2] = 16'h3333; prog[3] = 16'h4444;

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 16'h0);
    model_reset();
    #3;
    chk("rst_pc", pc, 0);
    chk("rst_pcadd4", pcadd4, 1);
    chk("rst_valid", inst_valid, 0);
    chk("rst_inst", inst, 16'h0000);
    chk("rst_halted", halted, 0);
    chk("rst_count", fetch_count, 0);
    cyc();

    // Program words 0..3 while stalled; first cycle is BOOT.
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 1, i, prog[i]);
      settle();
      if (i == 0) chk("boot_valid", inst_valid, 0);
      adv();
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 16'h0);
      settle();
      chk("seq_pc", pc, i);
      chk("seq_inst", inst, prog[i]);
      chk("seq_pcadd4", pcadd4, i + 1);
      adv();
    end
    settle();
    chk("seq_count", fetch_count, 4);
    adv();

    // Wrap-around from 14.
    drive(0, 1, 14, 0, 0, 16'h0); cyc();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 16'h0);
      settle();
      chk("wrap_pc", pc, (14 + i) % 16);
      if (i == 1) chk("wrap_pcadd4", pcadd4, 0);
      adv();
    end

    // Stall for 3 cycles at pc 5.
    drive(0, 1, 5, 0, 0, 16'h0); cyc();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 16'h0);
      settle();
      chk("stall_pc", pc, 5);
      adv();
    end
    drive(0, 0, 0, 0, 0, 16'h0); cyc();
    settle();
    chk("unstall_pc", pc, 6);
    adv();

    // Branch together with stall at pc 3.
    drive(0, 1, 3, 0, 0, 16'h0); cyc();
    drive(1, 1, 9, 0, 0, 16'h0);
    settle();
    chk("bs_flush", flush, 1);
    chk("bs_valid", inst_valid, 0);
    adv();
    drive(0, 0, 0, 0, 0, 16'h0);
    settle();
    chk("bs_pc", pc, 9);
    adv();

    // Halt word at 7.
    drive(1, 0, 0, 1, 7, 16'hFFFF); cyc();
    drive(0, 1, 7, 0, 0, 16'h0); cyc();
    drive(0, 0, 0, 0, 0, 16'h0);
    settle();
    chk("halt_issue_inst", inst, 16'hFFFF);
    chk("halt_issue_valid", inst_valid, 1);
    adv();
    for (int i = 0; i < 10; i++) begin
      drive(i % 2, 0, 0, 0, 0, 16'h0);
      settle();
      chk("halt_halted", halted, 1);
      chk("halt_pc", pc, 7);
      chk("halt_inst", inst, 16'h0000);
      adv();
    end
    drive(0, 1, 2, 0, 0, 16'h0); cyc();
    drive(0, 0, 0, 0, 0, 16'h0);
    settle();
    chk("resume_pc", pc, 2);
    chk("resume_halted", halted, 0);
    adv();

    // Asynchronous reset mid-cycle at pc 10.
    drive(0, 1, 10, 0, 0, 16'h0); cyc();
    drive(0, 0, 0, 0, 0, 16'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc", pc, 0);
    chk("arst_count", fetch_count, 0);
    chk("arst_valid", inst_valid, 0);
    model_reset();
    cyc();
    rst_n = 1'b1;
    settle();
    chk("arst_boot_valid", inst_valid, 0);
    adv();
    settle();
    chk("arst_mem0", inst, 16'h0000);
    chk("arst_valid1", inst_valid, 1);
    adv();

    // Counter saturation: memory is all NOP, no halt possible.
    for (int i = 0; i < 260; i++) cyc();
    settle();
    chk("sat_count", fetch_count, 255);
    adv();

    // Randomized phase against the model.
    for (int i = 0; i < 600; i++) begin
      logic [15:0] d;
      d = ($urandom_range(3) == 0) ? 16'hFFFF : 16'($urandom);
      drive($urandom_range(3) == 0, $urandom_range(7) == 0, $urandom_range(15),
            $urandom_range(3) == 0, $urandom_range(15), d);
      if ($urandom_range(149) == 0) begin
        #2 rst_n = 1'b0;
        #1 model_reset();
        cyc();
        rst_n = 1'b1;
      end else begin
        cyc();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
